// File: rtl/peripheral_stats_reader_if.sv
// peripheral_stats_reader_if: cs port between the statistics reader (master) and the peripheral responder (slave)
interface peripheral_stats_reader_if #(
    parameter int ADDR_W = 16
);
    logic              req_cs;
    logic              rw_cs;
    logic [ADDR_W-1:0] add_cs;
    logic [31:0]       wdata_cs;
    logic [31:0]       rdata_cs;
    modport master (output req_cs, rw_cs, add_cs, wdata_cs, input rdata_cs);
    modport slave  (input req_cs, rw_cs, add_cs, wdata_cs, output rdata_cs);
endinterface

// File: rtl/peripheral_stats_reader.sv
// peripheral_stats_reader: fetches a run of statistics words over the cs bus and streams them downstream
module peripheral_stats_reader #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] STATS_ADDR = 16'h0100
) (
    input  logic                      clock_i,
    input  logic                      resetn_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [2:0]                first_i,
    input  logic [2:0]                count_i,
    peripheral_stats_reader_if.master cs,
    output logic [31:0]               word_data_o,
    output logic [2:0]                word_idx_o,
    output logic                      word_valid_o,
    input  logic                      word_ready_i,
    output logic                      busy_o,
    output logic                      done_o
);
    typedef enum logic [2:0] {IDLE, WR_SEL, RD_REQ, RD_WAIT, PUSH, DONE} state_t;
    state_t     state;
    logic [2:0] idx;
    logic [2:0] rem;
    // Sequencer: every output is registered alongside the state it belongs to, bus idle unless set
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state        <= IDLE;
            idx          <= '0;
            rem          <= '0;
            cs.req_cs    <= 1'b0;
            cs.rw_cs     <= 1'b0;
            cs.add_cs    <= '0;
            cs.wdata_cs  <= '0;
            word_data_o  <= '0;
            word_idx_o   <= '0;
            word_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            cs.req_cs   <= 1'b0;
            cs.rw_cs    <= 1'b0;
            cs.add_cs   <= '0;
            cs.wdata_cs <= '0;
            done_o      <= 1'b0;
            if (abort_i && state != IDLE) begin
                state        <= IDLE;
                word_valid_o <= 1'b0;
                busy_o       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        busy_o <= 1'b1;
                        if (count_i == 3'd0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state       <= WR_SEL;
                            idx         <= first_i;
                            rem         <= count_i;
                            cs.req_cs   <= 1'b1;
                            cs.rw_cs    <= 1'b1;
                            cs.add_cs   <= STATS_ADDR;
                            cs.wdata_cs <= {29'b0, first_i};
                        end
                    end
                    WR_SEL: begin
                        state     <= RD_REQ;
                        cs.req_cs <= 1'b1;
                        cs.add_cs <= STATS_ADDR;
                    end
                    RD_REQ: state <= RD_WAIT;
                    RD_WAIT: begin
                        state        <= PUSH;
                        word_data_o  <= cs.rdata_cs;
                        word_idx_o   <= idx;
                        word_valid_o <= 1'b1;
                    end
                    PUSH: if (word_ready_i) begin
                        word_valid_o <= 1'b0;
                        rem          <= rem - 3'd1;
                        idx          <= idx + 3'd1;
                        if (rem == 3'd1) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state       <= WR_SEL;
                            cs.req_cs   <= 1'b1;
                            cs.rw_cs    <= 1'b1;
                            cs.add_cs   <= STATS_ADDR;
                            cs.wdata_cs <= {29'b0, idx + 3'd1};
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_peripheral_stats_reader.sv
// tb_peripheral_stats_reader: randomized scoreboard bench with a behavioural responder and word model
module tb_peripheral_stats_reader;
    localparam int          ADDR_W     = 16;
    localparam logic [15:0] STATS_ADDR = 16'h0100;

    logic        clock_i = 1'b0;
    logic        resetn_i = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        word_ready_i = 1'b0;
    logic [2:0]  first_i = '0;
    logic [2:0]  count_i = '0;
    logic [31:0] word_data_o;
    logic [2:0]  word_idx_o;
    logic        word_valid_o, busy_o, done_o;

    peripheral_stats_reader_if #(.ADDR_W(ADDR_W)) cs ();

    peripheral_stats_reader #(.ADDR_W(ADDR_W), .STATS_ADDR(STATS_ADDR)) dut (
        .clock_i(clock_i), .resetn_i(resetn_i), .start_i(start_i), .abort_i(abort_i),
        .first_i(first_i), .count_i(count_i), .cs(cs),
        .word_data_o(word_data_o), .word_idx_o(word_idx_o), .word_valid_o(word_valid_o),
        .word_ready_i(word_ready_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {logic [31:0] d; logic [2:0] i;} wd_t;
    wd_t         exp_q[$];
    logic [2:0]  wr_q[$];
    logic [31:0] stat[8];
    logic [2:0]  sel;
    int checks = 0, failures = 0;
    int done_pend = 0, done_cyc = 0, s_cyc = 0, cyc = 0, req_cnt = 0, rmode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        failures++;
        $display("FAIL %s unexpected event", name);
    endtask

    // responder: selector register plus registered readback, zero for unimplemented indices 6 and 7
    always @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sel         <= '0;
            cs.rdata_cs <= '0;
        end else if (cs.req_cs && cs.add_cs == STATS_ADDR) begin
            if (cs.rw_cs) sel <= cs.wdata_cs[2:0];
            else cs.rdata_cs <= (sel < 3'd6) ? stat[sel] : 32'd0;
        end
    end

    always @(posedge clock_i) cyc <= cyc + 1;

    // downstream ready: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clock_i) begin
        #2;
        word_ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // monitor: pops the scoreboard on every accepted word, bus write and done pulse
    always @(negedge clock_i) begin
        if (resetn_i) begin
            if (word_valid_o && word_ready_i) begin
                wd_t e;
                if (exp_q.size() == 0) bad("word_extra");
                else begin
                    e = exp_q.pop_front();
                    chk("word_data", word_data_o, e.d);
                    chk("word_idx", 32'(word_idx_o), 32'(e.i));
                end
            end
            if (cs.req_cs) begin
                req_cnt++;
                chk("bus_addr", 32'(cs.add_cs), 32'(STATS_ADDR));
                if (cs.rw_cs) begin
                    if (wr_q.size() == 0) bad("bus_write_extra");
                    else chk("bus_wr_sel", cs.wdata_cs, {29'b0, wr_q.pop_front()});
                end else chk("bus_rd_data", cs.wdata_cs, 32'd0);
            end
            if (done_o) begin
                done_cyc = cyc - s_cyc + 1;
                if (done_pend == 0) bad("done_extra");
                else done_pend--;
            end
        end
    end

    task automatic start_run(input logic [2:0] f, input logic [2:0] n);
        for (int k = 0; k < int'(n); k++) begin
            logic [2:0] ix;
            ix = f + 3'(k);
            exp_q.push_back({(ix < 3'd6) ? stat[ix] : 32'd0, ix});
            wr_q.push_back(ix);
        end
        done_pend++;
        first_i = f;
        count_i = n;
        start_i = 1'b1;
        @(posedge clock_i);
        #1;
        s_cyc = cyc;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (done_pend > 0 && t < budget) begin
            @(posedge clock_i);
            t++;
        end
        #1;
        if (done_pend > 0) begin
            bad("done_timeout");
            done_pend = 0;
        end
        chk("words_left", 32'(exp_q.size()), 32'd0);
        chk("writes_left", 32'(wr_q.size()), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic flush();
        exp_q.delete();
        wr_q.delete();
        done_pend = 0;
    endtask

    initial begin
        int r;
        for (int k = 0; k < 8; k++) stat[k] = (k < 6) ? 32'(8'h11 * (k + 1)) : 32'hdead_0000;
        repeat (3) @(posedge clock_i);
        #1;
        chk("rst_req", 32'(cs.req_cs), 32'd0);
        chk("rst_valid", 32'(word_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_data", word_data_o, 32'd0);
        resetn_i = 1'b1;
        @(posedge clock_i);
        #1;
        r = req_cnt;
        start_run(3'd0, 3'd6);
        chk("t1_busy", 32'(busy_o), 32'd1);
        wait_done(100);
        chk("t1_done_cycle", 32'(done_cyc), 32'd25);
        chk("t1_bus_reqs", 32'(req_cnt - r), 32'd12);
        start_run(3'd5, 3'd3);
        wait_done(100);
        chk("t2_done_cycle", 32'(done_cyc), 32'd13);
        r = req_cnt;
        start_run(3'd2, 3'd0);
        wait_done(20);
        chk("t3_done_cycle", 32'(done_cyc), 32'd1);
        chk("t3_bus_reqs", 32'(req_cnt - r), 32'd0);
        rmode = 2;
        start_run(3'd2, 3'd2);
        r = 0;
        while (!word_valid_o && r < 20) begin
            @(posedge clock_i);
            #1;
            r++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clock_i);
            chk("t4_valid", 32'(word_valid_o), 32'd1);
            chk("t4_data", word_data_o, stat[2]);
            chk("t4_req", 32'(cs.req_cs), 32'd0);
            @(posedge clock_i);
            #1;
        end
        rmode = 0;
        wait_done(100);
        start_run(3'd1, 3'd4);
        repeat (5) @(posedge clock_i);
        #1;
        chk("t5_rd_req", {31'b0, cs.req_cs & ~cs.rw_cs}, 32'd1);
        chk("t5_words_left", 32'(exp_q.size()), 32'd3);
        abort_i = 1'b1;
        @(posedge clock_i);
        #1;
        abort_i = 1'b0;
        flush();
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_valid", 32'(word_valid_o), 32'd0);
        r = req_cnt;
        repeat (6) @(posedge clock_i);
        #1;
        chk("t5_no_req", 32'(req_cnt - r), 32'd0);
        start_run(3'd3, 3'd2);
        wait_done(100);
        chk("t5_restart_done", 32'(done_cyc), 32'd9);
        start_run(3'd0, 3'd3);
        #2;
        resetn_i = 1'b0;
        #1;
        chk("t6_req", 32'(cs.req_cs), 32'd0);
        chk("t6_valid", 32'(word_valid_o), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        flush();
        @(posedge clock_i);
        #1;
        resetn_i = 1'b1;
        start_run(3'd4, 3'd2);
        @(posedge clock_i);
        #1;
        first_i = 3'd0;
        count_i = 3'd7;
        start_i = 1'b1;
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        wait_done(100);
        chk("t6_done_cycle", 32'(done_cyc), 32'd9);
        rmode = 1;
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < 6; k++) stat[k] = $urandom;
            start_run(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            wait_done(500);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
